// File: rtl/snn_sched_pkg.sv
// Shared types and default sizing for the neuron tick scheduler.
// Defaults: 256 neurons per core, 64-cycle handshake watchdog.
package snn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CALC  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  localparam int NUM_NEURONS_DEF = 256;
  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int NEURON_W        = $clog2(NUM_NEURONS_DEF);
  localparam int TIMEOUT_W       = $clog2(TIMEOUT_CYC_DEF + 1);

  // A single-neuron core still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_tick_scheduler_spike_collector.sv
// Working spike register for the tick in flight plus the published vector.
// Commit merges the same-cycle bit write so the last neuron lands in the output.
module spike_collector
  import snn_sched_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int IDX_W       = idx_width(NUM_NEURONS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   wr_en_i,
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  logic                   wr_bit_i,
  input  logic                   commit_i,
  output logic [NUM_NEURONS-1:0] spikes_o
);

  logic [NUM_NEURONS-1:0] working_q, working_d;
  logic [NUM_NEURONS-1:0] spikes_q, spikes_d;
  logic [NUM_NEURONS-1:0] merged;

  always_comb begin
    merged = working_q;
    if (wr_en_i) begin
      merged[wr_idx_i] = wr_bit_i;
    end
    working_d = clr_i ? '0 : merged;
    spikes_d  = commit_i ? merged : spikes_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      working_q <= '0;
      spikes_q  <= '0;
    end else begin
      working_q <= working_d;
      spikes_q  <= spikes_d;
    end
  end

  assign spikes_o = spikes_q;

endmodule

// File: rtl/neuron_tick_scheduler.sv
// Walks every neuron of a core once per tick: fetch params, strobe the update, collect the spike.
// Optional handshake watchdog enabled by defining SCHED_TIMEOUT_EN.
module neuron_tick_scheduler
  import snn_sched_pkg::*;
#(
  parameter  int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter  int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int NW          = idx_width(NUM_NEURONS)
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   tick_i,
  output logic [NW-1:0]          neuron_idx_o,
  output logic                   param_req_o,
  input  logic                   param_ack_i,
  output logic                   enable_calc_o,
  input  logic                   calc_done_i,
  input  logic                   spike_i,
  output logic [NUM_NEURONS-1:0] spikes_o,
  output logic                   spikes_valid_o,
  output logic                   busy_o,
  output logic                   overrun_o,
  output logic                   timeout_o
);

  localparam logic [NW-1:0] LAST_IDX = NW'(NUM_NEURONS - 1);

  sched_state_t  state_q, state_d;
  logic [NW-1:0] idx_q, idx_d;
  logic          param_req_q, param_req_d;
  logic          enable_calc_q, enable_calc_d;
  logic          busy_q, busy_d;
  logic          spikes_valid_q, spikes_valid_d;
  logic          overrun_q, overrun_d;
  logic          kill_q, kill_d;

  logic          expire;
  logic          clr_work;
  logic          wr_en;
  logic          wr_bit;
  logic          commit;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q | (tick_i && (state_q != IDLE));
    kill_d    = kill_q;
    clr_work  = 1'b0;
    wr_en     = 1'b0;
    wr_bit    = 1'b0;
    commit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick_i) begin
          state_d  = FETCH;
          idx_d    = '0;
          clr_work = 1'b1;
        end
      end
      FETCH: begin
        if (param_ack_i) begin
          state_d = CALC;
        end else if (expire) begin
          // Parameters never arrived: run the update anyway but drop its spike.
          state_d = CALC;
          kill_d  = 1'b1;
        end
      end
      CALC: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (calc_done_i || expire) begin
          wr_en  = 1'b1;
          wr_bit = calc_done_i && spike_i && !kill_q;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == FETCH && state_q != FETCH) begin
      kill_d = 1'b0;
    end

    param_req_d    = (state_d == FETCH);
    enable_calc_d  = (state_d == CALC);
    busy_d         = (state_d == FETCH) || (state_d == CALC) || (state_d == WAIT);
    spikes_valid_d = (state_d == DONE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      param_req_q    <= 1'b0;
      enable_calc_q  <= 1'b0;
      busy_q         <= 1'b0;
      spikes_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      kill_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      param_req_q    <= param_req_d;
      enable_calc_q  <= enable_calc_d;
      busy_q         <= busy_d;
      spikes_valid_q <= spikes_valid_d;
      overrun_q      <= overrun_d;
      kill_q         <= kill_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Counter restarts on every state entry, so each handshake gets a full window.
  assign expire = ((state_q == FETCH) || (state_q == WAIT)) &&
                  (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == FETCH) || (state_q == WAIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
    timeout_d = timeout_q |
                (expire && (((state_q == FETCH) && !param_ack_i) ||
                            ((state_q == WAIT) && !calc_done_i)));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  spike_collector #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (NW)
  ) u_collector (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clr_i    (clr_work),
    .wr_en_i  (wr_en),
    .wr_idx_i (idx_q),
    .wr_bit_i (wr_bit),
    .commit_i (commit),
    .spikes_o (spikes_o)
  );

  assign neuron_idx_o   = idx_q;
  assign param_req_o    = param_req_q;
  assign enable_calc_o  = enable_calc_q;
  assign busy_o         = busy_q;
  assign spikes_valid_o = spikes_valid_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_neuron_tick_scheduler.sv
// Directed bench for a 4-neuron scheduler with a reactive ack/done responder.
module tb_neuron_tick_scheduler;

  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick_i = 1'b0;
  logic [1:0]   neuron_idx_o;
  logic         param_req_o;
  logic         param_ack_i = 1'b0;
  logic         enable_calc_o;
  logic         calc_done_i = 1'b0;
  logic         spike_i = 1'b0;
  logic [N-1:0] spikes_o;
  logic         spikes_valid_o;
  logic         busy_o;
  logic         overrun_o;
  logic         timeout_o;

  neuron_tick_scheduler #(.NUM_NEURONS(N), .TIMEOUT_CYC(TO)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .tick_i         (tick_i),
    .neuron_idx_o   (neuron_idx_o),
    .param_req_o    (param_req_o),
    .param_ack_i    (param_ack_i),
    .enable_calc_o  (enable_calc_o),
    .calc_done_i    (calc_done_i),
    .spike_i        (spike_i),
    .spikes_o       (spikes_o),
    .spikes_valid_o (spikes_valid_o),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] pat = '0;
  bit           rand_mode = 1'b0;
  int           withhold = -1;
  int           ack_cnt = 0, ack_cur = 0;
  int           d_cnt = 0, d_cur = 0;
  bit           waiting = 1'b0;

  int           sv_count = 0;
  int           ec_count = 0;
  int           idx_seq[8];
  int           busy_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Datapath model: ack after ack_cur cycles of request, done after d_cur WAIT cycles.
  always @(negedge clk) begin
    if (param_req_o) begin
      if (ack_cnt >= ack_cur) param_ack_i = 1'b1;
      else begin
        param_ack_i = 1'b0;
        ack_cnt++;
      end
    end else begin
      param_ack_i = 1'b0;
      ack_cnt = 0;
      ack_cur = rand_mode ? int'($urandom_range(0, 5)) : 0;
    end

    if (enable_calc_o) begin
      waiting = 1'b1;
      d_cnt = 0;
      d_cur = rand_mode ? int'($urandom_range(0, 5)) : 0;
      calc_done_i = 1'b0;
    end else if (waiting) begin
      if (d_cnt >= d_cur && int'(neuron_idx_o) != withhold) begin
        calc_done_i = 1'b1;
        spike_i = pat[neuron_idx_o];
        waiting = 1'b0;
      end else begin
        calc_done_i = 1'b0;
        d_cnt++;
      end
    end else begin
      calc_done_i = 1'b0;
      spike_i = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (spikes_valid_o) sv_count++;
    if (enable_calc_o) begin
      if (ec_count < 8) idx_seq[ec_count] = int'(neuron_idx_o);
      ec_count++;
    end
  end

  task automatic run_tick(output int cyc);
    tick_i = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      tick_i = 1'b0;
      cyc++;
      if (!spikes_valid_o && !busy_o) busy_bad++;
    end while (!spikes_valid_o && cyc < 500);
    if (!spikes_valid_o) check("tick_completes", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    int guard;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_idx", neuron_idx_o, 0);
    check("rst_req", param_req_o, 0);
    check("rst_en", enable_calc_o, 0);
    check("rst_spikes", spikes_o, 0);
    check("rst_valid", spikes_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_timeout", timeout_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: zero-wait handshakes, pattern 1,0,1,1
    pat = 4'b1101;
    busy_bad = 0;
    run_tick(cyc);
    check("t1_latency", cyc, 13);
    check("t1_spikes", spikes_o, 4'b1101);
    check("t1_busy_low_at_done", busy_o, 0);
    @(negedge clk);
    check("t1_valid_one_cycle", spikes_valid_o, 0);
    check("t1_spikes_hold", spikes_o, 4'b1101);

    // 2: random handshake delays
    rand_mode = 1'b1;
    pat = 4'b0110;
    ec_count = 0;
    busy_bad = 0;
    repeat (2) @(negedge clk);
    run_tick(cyc);
    repeat (3) @(negedge clk);
    check("t2_enable_pulses", ec_count, 4);
    check("t2_idx0", idx_seq[0], 0);
    check("t2_idx1", idx_seq[1], 1);
    check("t2_idx2", idx_seq[2], 2);
    check("t2_idx3", idx_seq[3], 3);
    check("t2_busy_gaps", busy_bad, 0);
    check("t2_spikes", spikes_o, 4'b0110);
    check("t2_min_latency", (cyc >= 13), 1);
    rand_mode = 1'b0;

    // 3: overrun mid-tick and in the DONE cycle
    pat = 4'b0011;
    sv_count = 0;
    tick_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0;
    repeat (5) @(negedge clk);
    tick_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0;
    guard = 0;
    while (!spikes_valid_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("t3_reached_done", spikes_valid_o, 1);
    pat = 4'b1111;
    tick_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0;
    repeat (60) @(negedge clk);
    check("t3_overrun", overrun_o, 1);
    check("t3_one_valid", sv_count, 1);
    check("t3_spikes_first_only", spikes_o, 4'b0011);
    check("t3_not_restarted", busy_o, 0);

    // 4: reset while idx=2
    pat = 4'b1010;
    sv_count = 0;
    tick_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0;
    guard = 0;
    while (neuron_idx_o != 2'd2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("t4_reached_idx2", neuron_idx_o, 2);
    rst = 1'b1;
    @(negedge clk);
    check("t4_idx", neuron_idx_o, 0);
    check("t4_req", param_req_o, 0);
    check("t4_en", enable_calc_o, 0);
    check("t4_busy", busy_o, 0);
    check("t4_spikes", spikes_o, 0);
    check("t4_overrun", overrun_o, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t4_no_valid", sv_count, 0);
    run_tick(cyc);
    check("t4_fresh_latency", cyc, 13);
    check("t4_fresh_spikes", spikes_o, 4'b1010);

    // 6: back-to-back all ones then all zeros
    @(negedge clk);
    pat = 4'b1111;
    run_tick(cyc);
    check("t6_all_ones", spikes_o, 4'hF);
    @(negedge clk);
    pat = 4'b0000;
    run_tick(cyc);
    check("t6_all_zeros", spikes_o, 4'h0);

    // 5: watchdog on a withheld calc_done for neuron 1
`ifdef SCHED_TIMEOUT_EN
    @(negedge clk);
    pat = 4'b1111;
    withhold = 1;
    run_tick(cyc);
    withhold = -1;
    check("t5_timeout", timeout_o, 1);
    check("t5_spikes", spikes_o, 4'b1101);
    check("t5_latency", cyc, 20);
`else
    check("t5_timeout_tied", timeout_o, 0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
